// File: rtl/prefetch_queue.sv
// rtl/prefetch_queue.sv - byte-wide instruction prefetch queue with word fetch, multi-byte consume and flush
module prefetch_queue #(
    parameter int DEPTH = 6
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ce,
    input  logic        flush,
    input  logic [15:0] flush_addr,
    output logic        fetch_req,
    output logic [15:0] fetch_addr,
    input  logic        fetch_ack,
    input  logic [15:0] fetch_data,
    input  logic        consume,
    input  logic [2:0]  consume_len,
    output logic [3:0]  q_len,
    output logic [7:0]  q0,
    output logic [7:0]  q1,
    output logic [7:0]  q2,
    output logic [15:0] ip
);

    localparam logic [3:0] DEPTH_L = 4'(DEPTH);

    logic [7:0]  mem [DEPTH];
    logic [2:0]  rd_ptr;
    logic [2:0]  wr_ptr;
    logic [3:0]  count;
    logic [3:0]  free;
    logic        space_ok;
    logic        xfer;
    logic [3:0]  push_n;
    logic [3:0]  pop_n;

    // Pointer sum stays below 2*DEPTH, so one conditional subtract wraps it.
    function automatic logic [2:0] wrap_add(input logic [2:0] p, input logic [3:0] a);
        logic [3:0] s;
        s = {1'b0, p} + a;
        if (s >= DEPTH_L) s = s - DEPTH_L;
        return s[2:0];
    endfunction

    always_comb begin
        free     = DEPTH_L - count;
        space_ok = fetch_addr[0] ? (free >= 4'd1) : (free >= 4'd2);
        fetch_req = reset_n & ce & ~flush & space_ok;
        xfer     = fetch_req & fetch_ack;
        push_n   = xfer ? (fetch_addr[0] ? 4'd1 : 4'd2) : 4'd0;
        pop_n    = 4'd0;
        if (consume) pop_n = ({1'b0, consume_len} > count) ? count : {1'b0, consume_len};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            ip         <= '0;
            fetch_addr <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (ce) begin
            if (flush) begin
                rd_ptr     <= '0;
                wr_ptr     <= '0;
                count      <= '0;
                ip         <= flush_addr;
                fetch_addr <= flush_addr;
            end else begin
                rd_ptr <= wrap_add(rd_ptr, pop_n);
                ip     <= ip + 16'(pop_n);
                count  <= count - pop_n + push_n;
                if (xfer) begin
                    wr_ptr     <= wrap_add(wr_ptr, push_n);
                    fetch_addr <= fetch_addr + 16'(push_n);
                    if (fetch_addr[0]) begin
                        mem[wr_ptr] <= fetch_data[15:8];
                    end else begin
                        mem[wr_ptr]                <= fetch_data[7:0];
                        mem[wrap_add(wr_ptr, 4'd1)] <= fetch_data[15:8];
                    end
                end
            end
        end
    end

    always_comb begin
        q_len = count;
        q0 = (count > 4'd0) ? mem[rd_ptr]                  : 8'h00;
        q1 = (count > 4'd1) ? mem[wrap_add(rd_ptr, 4'd1)] : 8'h00;
        q2 = (count > 4'd2) ? mem[wrap_add(rd_ptr, 4'd2)] : 8'h00;
    end

endmodule

// File: tb/tb_prefetch_queue.sv
// tb/tb_prefetch_queue.sv - randomized and directed bench for prefetch_queue against a byte-queue model
module tb_prefetch_queue;

    localparam int DEPTH = 6;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ce;
    logic        flush;
    logic [15:0] flush_addr;
    logic        fetch_req;
    logic [15:0] fetch_addr;
    logic        fetch_ack;
    logic [15:0] fetch_data;
    logic        consume;
    logic [2:0]  consume_len;
    logic [3:0]  q_len;
    logic [7:0]  q0, q1, q2;
    logic [15:0] ip;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]  mq[$];
    logic [15:0] m_ip;
    logic [15:0] m_fa;

    prefetch_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n), .ce(ce), .flush(flush), .flush_addr(flush_addr),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ack(fetch_ack),
        .fetch_data(fetch_data), .consume(consume), .consume_len(consume_len),
        .q_len(q_len), .q0(q0), .q1(q1), .q2(q2), .ip(ip)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit m_req();
        int fr;
        fr = DEPTH - mq.size();
        return reset_n && ce && !flush && (m_fa[0] ? (fr >= 1) : (fr >= 2));
    endfunction

    function automatic logic [7:0] m_byte(input int i);
        return (i < mq.size()) ? mq[i] : 8'h00;
    endfunction

    task automatic m_clear(input logic [15:0] a);
        mq.delete();
        m_ip = a;
        m_fa = a;
    endtask

    task automatic check_outs();
        chk("q_len", 32'(q_len), 32'(mq.size()));
        chk("q0", 32'(q0), 32'(m_byte(0)));
        chk("q1", 32'(q1), 32'(m_byte(1)));
        chk("q2", 32'(q2), 32'(m_byte(2)));
        chk("ip", 32'(ip), 32'(m_ip));
        chk("fetch_addr", 32'(fetch_addr), 32'(m_fa));
    endtask

    task automatic step(input bit c, input bit fl, input logic [15:0] fa, input bit ak,
                        input logic [15:0] fd, input bit cs, input logic [2:0] cl);
        bit req;
        int n;
        ce = c; flush = fl; flush_addr = fa; fetch_ack = ak; fetch_data = fd;
        consume = cs; consume_len = cl;
        #1;
        req = m_req();
        chk("fetch_req", 32'(fetch_req), 32'(req));
        @(posedge clk);
        if (c) begin
            if (fl) begin
                m_clear(fa);
            end else begin
                n = cs ? ((int'(cl) < mq.size()) ? int'(cl) : mq.size()) : 0;
                for (int i = 0; i < n; i++) void'(mq.pop_front());
                m_ip = m_ip + 16'(n);
                if (req && ak) begin
                    if (m_fa[0]) begin
                        mq.push_back(fd[15:8]);
                        m_fa = m_fa + 16'd1;
                    end else begin
                        mq.push_back(fd[7:0]);
                        mq.push_back(fd[15:8]);
                        m_fa = m_fa + 16'd2;
                    end
                end
            end
        end
        #1;
        check_outs();
    endtask

    initial begin
        reset_n = 1'b0; ce = 1'b0; flush = 1'b0; flush_addr = '0; fetch_ack = 1'b0;
        fetch_data = '0; consume = 1'b0; consume_len = '0;
        m_clear(16'h0000);
        @(posedge clk); #1;
        check_outs();
        chk("reset_req", 32'(fetch_req), 32'd0);
        reset_n = 1'b1;

        // Reset, then fill
        step(1, 0, 0, 1, 16'h1234, 0, 0);
        chk("fill_len2", 32'(q_len), 32'd2);
        step(1, 0, 0, 1, 16'h5678, 0, 0);
        chk("fill_len4", 32'(q_len), 32'd4);
        step(1, 0, 0, 1, 16'hABCD, 0, 0);
        chk("fill_len6", 32'(q_len), 32'd6);
        chk("fill_q", {8'h00, q0, q1, q2}, 32'h00341278);
        chk("fill_fa", 32'(fetch_addr), 32'h0006);
        step(1, 0, 0, 1, 16'h9999, 0, 0);

        // Odd flush
        step(1, 1, 16'h0101, 0, 0, 0, 0);
        step(1, 0, 0, 1, 16'hEE55, 0, 0);
        chk("odd_q", {4'h0, q_len, q0, q1, q2}, 32'h01EE0000);
        chk("odd_fa", 32'(fetch_addr), 32'h0102);
        chk("odd_ip", 32'(ip), 32'h0101);

        // Full queue with simultaneous consume and ack
        step(1, 1, 16'h0200, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 1, 16'(i * 16'h1111 + 16'h0102), 0, 0);
        step(1, 0, 0, 1, 16'h7777, 1, 3);
        chk("full_pp_len", 32'(q_len), 32'd3);
        chk("full_pp_ip", 32'(ip), 32'h0203);
        step(1, 0, 0, 1, 16'h8888, 0, 0);
        chk("full_next_len", 32'(q_len), 32'd5);

        // Over-consume and address wrap
        step(1, 1, 16'h0010, 0, 0, 0, 0);
        step(1, 0, 0, 1, 16'h2211, 0, 0);
        step(1, 0, 0, 0, 0, 1, 5);
        chk("over_len", 32'(q_len), 32'd0);
        chk("over_ip", 32'(ip), 32'h0012);
        step(1, 1, 16'hFFFE, 0, 0, 0, 0);
        step(1, 0, 0, 1, 16'hBBAA, 0, 0);
        chk("wrap_fa", 32'(fetch_addr), 32'h0000);
        step(1, 0, 0, 0, 0, 1, 2);
        chk("wrap_ip", 32'(ip), 32'h0000);
        step(1, 1, 16'hFFFF, 0, 0, 0, 0);
        step(1, 0, 0, 1, 16'hCC00, 0, 0);
        chk("odd_wrap_fa", 32'(fetch_addr), 32'h0000);

        // Flush priority over consume and ack
        step(1, 0, 0, 1, 16'h3344, 0, 0);
        step(1, 1, 16'h4000, 1, 16'h5555, 1, 1);
        chk("flush_len", 32'(q_len), 32'd0);
        chk("flush_ip", 32'(ip), 32'h4000);

        // ce gating
        step(1, 0, 0, 1, 16'h6655, 0, 0);
        step(0, 0, 0, 1, 16'h9988, 1, 3);
        step(0, 1, 16'h1234, 1, 16'h9988, 1, 1);

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            logic [15:0] fa;
            fa = ($urandom_range(0, 3) == 0) ? 16'(16'hFFFC + $urandom_range(0, 3)) : 16'($urandom);
            step($urandom_range(0, 9) != 0, $urandom_range(0, 19) == 0, fa,
                 $urandom_range(0, 2) != 0, 16'($urandom), $urandom_range(0, 1) == 1,
                 3'($urandom_range(0, 6)));
        end

        // Asynchronous reset between edges
        #2;
        reset_n = 1'b0;
        #1;
        m_clear(16'h0000);
        check_outs();
        chk("areset_req", 32'(fetch_req), 32'd0);
        @(posedge clk); #3;
        reset_n = 1'b1;
        step(1, 0, 0, 1, 16'hA5A5, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
